ipf_feeder: RTL and testbench

IPF_FEEDER -- requirements
Module: ipf_feeder

---
 rtl/ipf_feeder.sv | 164 ++++++++++++++++
 tb/tb_ipf_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipf_feeder.sv
// Walks a 128x128 image LCU by LCU and streams its pixels to the in-loop filter.
// Each LCU's filter parameters are fetched before its pixels and held until its last pixel is out.
module ipf_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cfg_size,
    output logic        img_rd,
    output logic [13:0] img_addr,
    input  logic [7:0]  img_data,
    output logic        par_rd,
    output logic [5:0]  par_addr,
    input  logic [23:0] par_data,
    input  logic        busy,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [1:0]  ipf_type,
    output logic [4:0]  ipf_band_pos,
    output logic        ipf_wo_class,
    output logic [15:0] ipf_offset,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic [1:0]  lcu_size,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, PREQ, PLAT, STREAM, DRAIN, NEXT, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [2:0]  lcu_x_q, lcu_x_d;
    logic [2:0]  lcu_y_q, lcu_y_d;
    logic [5:0]  r_q, r_d;
    logic [5:0]  c_q, c_d;
    logic [23:0] prm_q, prm_d;
    logic        rd_vld_q;

    logic [1:0]  eff_code;
    logic [5:0]  pix_max;
    logic [2:0]  lcu_max;
    logic [6:0]  row, col;

    // Code 3 is an alias of 16x16; lcu_size still reports the raw latched code.
    assign eff_code = (size_q == 2'd3) ? 2'd0 : size_q;

    always_comb begin
        pix_max = 6'd15;
        lcu_max = 3'd7;
        case (eff_code)
            2'd1:    begin pix_max = 6'd31; lcu_max = 3'd3; end
            2'd2:    begin pix_max = 6'd63; lcu_max = 3'd1; end
            default: begin pix_max = 6'd15; lcu_max = 3'd7; end
        endcase
    end

    assign row      = ({4'b0, lcu_y_q} << (3'd4 + {1'b0, eff_code})) + {1'b0, r_q};
    assign col      = ({4'b0, lcu_x_q} << (3'd4 + {1'b0, eff_code})) + {1'b0, c_q};
    assign img_addr = {row, col};
    assign par_addr = ({3'b0, lcu_y_q} << (2'd3 - eff_code)) + {3'b0, lcu_x_q};

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        lcu_x_d = lcu_x_q;
        lcu_y_d = lcu_y_q;
        r_d     = r_q;
        c_d     = c_q;
        prm_d   = prm_q;
        img_rd  = 1'b0;
        par_rd  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    size_d  = cfg_size;
                    lcu_x_d = 3'd0;
                    lcu_y_d = 3'd0;
                    r_d     = 6'd0;
                    c_d     = 6'd0;
                    state_d = PREQ;
                end
            end
            PREQ: begin
                par_rd  = 1'b1;
                state_d = PLAT;
            end
            PLAT: begin
                prm_d   = par_data;
                state_d = STREAM;
            end
            STREAM: begin
                if (!busy) begin
                    img_rd = 1'b1;
                    if (c_q == pix_max) begin
                        c_d = 6'd0;
                        if (r_q == pix_max) begin
                            r_d     = 6'd0;
                            state_d = DRAIN;
                        end else begin
                            r_d = r_q + 6'd1;
                        end
                    end else begin
                        c_d = c_q + 6'd1;
                    end
                end
            end
            // DRAIN lets the last read's pixel leave before the next LCU's parameters load.
            DRAIN: state_d = NEXT;
            NEXT: begin
                if (lcu_x_q == lcu_max) begin
                    lcu_x_d = 3'd0;
                    if (lcu_y_q == lcu_max) begin
                        lcu_y_d = 3'd0;
                        state_d = DONE;
                    end else begin
                        lcu_y_d = lcu_y_q + 3'd1;
                        state_d = PREQ;
                    end
                end else begin
                    lcu_x_d = lcu_x_q + 3'd1;
                    state_d = PREQ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            size_q   <= 2'd0;
            lcu_x_q  <= 3'd0;
            lcu_y_q  <= 3'd0;
            r_q      <= 6'd0;
            c_q      <= 6'd0;
            prm_q    <= 24'd0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            lcu_x_q  <= lcu_x_d;
            lcu_y_q  <= lcu_y_d;
            r_q      <= r_d;
            c_q      <= c_d;
            prm_q    <= prm_d;
            rd_vld_q <= img_rd;
        end
    end

    assign in_en        = rd_vld_q;
    assign din          = rd_vld_q ? img_data : 8'd0;
    assign ipf_type     = prm_q[23:22];
    assign ipf_band_pos = prm_q[21:17];
    assign ipf_wo_class = prm_q[16];
    assign ipf_offset   = prm_q[15:0];
    assign lcu_x        = lcu_x_q;
    assign lcu_y        = lcu_y_q;
    assign lcu_size     = size_q;

endmodule

// File: tb/tb_ipf_feeder.sv
// Directed bench for ipf_feeder: ROM models, a negedge monitor scoring every read and pixel,
// and per-frame checks for 16/64 sizes, random busy, mid-frame reset and ignored start.
module tb_ipf_feeder;

    logic        clk = 1'b0;
    logic        reset, start, busy;
    logic [1:0]  cfg_size;
    logic        img_rd, par_rd, in_en, done;
    logic [13:0] img_addr;
    logic [7:0]  img_data, din;
    logic [5:0]  par_addr;
    logic [23:0] par_data;
    logic [1:0]  ipf_type, lcu_size;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x, lcu_y;

    ipf_feeder dut (
        .clk(clk), .reset(reset), .start(start), .cfg_size(cfg_size),
        .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
        .par_rd(par_rd), .par_addr(par_addr), .par_data(par_data),
        .busy(busy), .in_en(in_en), .din(din),
        .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class),
        .ipf_offset(ipf_offset), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size), .done(done)
    );

    always #5 clk = ~clk;

    // ROMs: image[a] = a[7:0], params[k] = k*0x10101, one cycle read latency
    always @(posedge clk) begin
        if (img_rd) img_data <= img_addr[7:0];
        if (par_rd) par_data <= 24'(par_addr * 32'h10101);
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(int k, int s);
        int n, lcu, p;
        n   = 128 / s;
        lcu = k / (s * s);
        p   = k % (s * s);
        return ((lcu / n) * s + p / s) * 128 + (lcu % n) * s + p % s;
    endfunction

    // Stimulus-owned frame context
    int frame_id = 0;
    int sz = 16;
    bit busy_rand = 0;

    // Monitor-owned statistics, cleared when frame_id changes
    int mon_fid = 0;
    int f_rd, f_en, f_par, f_done, en_at_done;
    int addr_bad, din_bad, par_bad, prm_bad, lat_bad, brd_bad;
    int a16, a_l1, a_l2, first_din;
    int act_cnt = 0;
    int m_k, m_n;
    logic prev_rd = 1'b0;
    logic [23:0] m_exp;

    always @(negedge clk) begin
        if (mon_fid != frame_id) begin
            mon_fid = frame_id;
            f_rd = 0; f_en = 0; f_par = 0; f_done = 0; en_at_done = -1;
            addr_bad = 0; din_bad = 0; par_bad = 0; prm_bad = 0; lat_bad = 0; brd_bad = 0;
            a16 = -1; a_l1 = -1; a_l2 = -1; first_din = -1;
        end
        if (img_rd || par_rd || in_en) act_cnt++;
        if (reset) begin
            prev_rd = 1'b0;
        end else begin
            if (in_en !== prev_rd) lat_bad++;
            prev_rd = img_rd;
        end
        if (img_rd && busy) brd_bad++;
        if (img_rd) begin
            if (img_addr !== 14'(exp_addr(f_rd, sz))) addr_bad++;
            if (f_rd == 16) a16 = int'(img_addr);
            if (f_rd == sz * sz) a_l1 = int'(img_addr);
            if (f_rd == 2 * sz * sz) a_l2 = int'(img_addr);
            f_rd++;
        end
        if (in_en) begin
            if (f_en == 0) first_din = int'(din);
            if (din !== 8'(exp_addr(f_en, sz))) din_bad++;
            m_k   = f_en / (sz * sz);
            m_n   = 128 / sz;
            m_exp = 24'(m_k * 32'h10101);
            if ({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} !== m_exp) prm_bad++;
            if (lcu_x !== 3'(m_k % m_n) || lcu_y !== 3'(m_k / m_n)) prm_bad++;
            f_en++;
        end
        if (par_rd) begin
            if (par_addr !== 6'(f_par)) par_bad++;
            f_par++;
        end
        if (done) begin
            f_done++;
            en_at_done = f_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy_rand) busy = ($urandom_range(0, 3) == 0);
    endtask

    task automatic start_frame(input logic [1:0] code);
        frame_id++;
        cfg_size = code;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_frame(input int budget, input bit pulses);
        int cyc;
        cyc = 0;
        while (f_done == 0 && cyc < budget) begin
            if (pulses) begin
                start = (cyc == 300 || cyc == 5000);
                if (cyc == 400) cfg_size = 2'd2;
                if (cyc == 600) chk("E_lcu_size", 32'(lcu_size), 3);
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("done_in_budget", 32'(f_done > 0), 1);
        repeat (5) tick();
    endtask

    task automatic frame_checks(input string tag, input int nlcu);
        chk({tag, "_pixels_at_done"}, en_at_done, 16384);
        chk({tag, "_reads"}, f_rd, 16384);
        chk({tag, "_done_cycles"}, f_done, 1);
        chk({tag, "_addr_bad"}, addr_bad, 0);
        chk({tag, "_din_bad"}, din_bad, 0);
        chk({tag, "_param_bad"}, prm_bad, 0);
        chk({tag, "_latency_bad"}, lat_bad, 0);
        chk({tag, "_rd_while_busy"}, brd_bad, 0);
        chk({tag, "_par_addr_bad"}, par_bad, 0);
        chk({tag, "_par_reads"}, f_par, nlcu);
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_ctl"}, 32'({img_rd, par_rd, in_en, done, lcu_x, lcu_y, lcu_size}), 0);
        chk({tag, "_addr"}, 32'({img_addr, par_addr, din}), 0);
        chk({tag, "_params"}, 32'({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}), 0);
    endtask

    initial begin
        int cyc, snap;
        reset = 1'b1; start = 1'b0; cfg_size = 2'd0; busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_checks("reset");
        @(posedge clk); #1 reset = 1'b0;

        // A: 16x16 LCUs, no backpressure
        sz = 16;
        start_frame(2'd0);
        run_frame(40000, 0);
        frame_checks("A", 64);
        chk("A_first_din", first_din, 0);
        chk("A_pix16_addr", a16, 128);

        // B: 64x64 LCUs
        sz = 64;
        start_frame(2'd2);
        run_frame(40000, 0);
        frame_checks("B", 4);
        chk("B_lcu1_first_addr", a_l1, 64);
        chk("B_lcu2_first_addr", a_l2, 8192);

        // C: random busy, same pixel order expected
        sz = 16;
        busy_rand = 1;
        start_frame(2'd0);
        run_frame(60000, 0);
        busy_rand = 0;
        busy = 1'b0;
        frame_checks("C", 64);

        // D: reset after 1000 pixels
        sz = 16;
        start_frame(2'd0);
        cyc = 0;
        while (f_en < 1000 && cyc < 5000) begin
            tick();
            cyc++;
        end
        chk("D_reached_1000", 32'(f_en >= 1000), 1);
        reset = 1'b1;
        @(negedge clk);
        rst_checks("D_abort");
        @(posedge clk); #1 reset = 1'b0;
        snap = act_cnt;
        repeat (50) tick();
        chk("D_idle_activity", act_cnt - snap, 0);

        // E: code 3 (16x16), restart from addr 0, start pulses and cfg change mid-frame
        sz = 16;
        start_frame(2'd3);
        run_frame(40000, 1);
        frame_checks("E", 64);
        chk("E_first_din", first_din, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
